// File: rtl/deserializer_pkg.sv
// deserializer_pkg: shared sizing, state encoding and helpers for the deserializer.
// No ports. Imported by deserializer_if, sync_edge_detect and deserializer.
package deserializer_pkg;
   localparam int WORD_WIDTH_DEFAULT = 12;
   typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DRAIN} state_t;
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/deserializer_if.sv
// deserializer_if: serial link inputs plus valid/ready parallel output of the deserializer.
// Ports: none. Modport slave = deserializer side, master = serializer/consumer side.
interface deserializer_if import deserializer_pkg::*; #(
   parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
);
   logic                  i_sclk;
   logic                  i_data_serial;
   logic                  i_data_sent;
   logic                  i_data_ready;
   logic [WORD_WIDTH-1:0] o_data_parallel;
   logic                  o_data_valid;
   logic                  o_busy;
   logic                  o_overrun;
   logic                  o_frame_err;
   modport slave (
      input  i_sclk, i_data_serial, i_data_sent, i_data_ready,
      output o_data_parallel, o_data_valid, o_busy, o_overrun, o_frame_err
   );
   modport master (
      output i_sclk, i_data_serial, i_data_sent, i_data_ready,
      input  o_data_parallel, o_data_valid, o_busy, o_overrun, o_frame_err
   );
endinterface

// File: rtl/deserializer_sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer for i_e and i_d, with rise/fall pulses on i_e only.
// Ports: i_clk, i_rst (sync, active-high), i_e (edge-detected input), i_d[W-1:0] (sync-only
// inputs), o_sync[W-1:0] (synchronized i_d), o_rise/o_fall (single-cycle pulses of i_e).
module sync_edge_detect import deserializer_pkg::*; #(
   parameter int W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_e,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_sync,
   output logic         o_rise,
   output logic         o_fall
);
   logic [W:0] meta_q, sync_q;
   logic       prev_q;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= {i_d, i_e};
         sync_q <= meta_q;
         prev_q <= sync_q[0];
      end
   end
   assign o_sync = sync_q[W:1];
   assign o_rise = sync_q[0] & ~prev_q;
   assign o_fall = ~sync_q[0] & prev_q;
endmodule

// File: rtl/deserializer.sv
// deserializer: oversamples a serializer's SCLK/data/idle lines and rebuilds MSB-first words.
// Ports: i_clk, i_rst (sync, active-high), bus (deserializer_if.slave: serial inputs,
// valid/ready parallel output, busy, overrun and frame-error pulses).
// Option: define DESERIALIZER_TIMEOUT_EN to abort a word when SCLK stalls TIMEOUT_CYCLES.
module deserializer import deserializer_pkg::*; #(
   parameter int WORD_WIDTH     = WORD_WIDTH_DEFAULT,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic           i_clk,
   input logic           i_rst,
   deserializer_if.slave bus
);
   localparam int CW = cnt_width(WORD_WIDTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef DESERIALIZER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [WORD_WIDTH-1:0] sr_q, sr_d, par_q, par_d;
   logic [TW-1:0]         wd_q, wd_d;
   logic                  valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
   logic [1:0]            sync;
   logic                  sclk_rise, sclk_fall, done, timeout;
   sync_edge_detect #(.W(2)) u_sync (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_e    (bus.i_sclk),
      .i_d    ({bus.i_data_sent, bus.i_data_serial}),
      .o_sync (sync),
      .o_rise (sclk_rise),
      .o_fall (sclk_fall)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      par_d   = par_q;
      valid_d = valid_q && !bus.i_data_ready;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
      done    = 1'b0;
      timeout = TO_EN && wd_q == TW'(TIMEOUT_CYCLES);
      // watchdog only runs while a word is expected; any SCLK edge restarts it
      wd_d    = (state_q inside {ARMED, SHIFT}) && !(sclk_rise || sclk_fall) ? wd_q + 1'b1 : '0;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            sr_d    = '0;
            state_d = sync[1] ? IDLE : ARMED;
         end
         ARMED: begin
            if (timeout) begin
               ferr_d  = 1'b1;
               state_d = DRAIN;
            end else if (sclk_rise) state_d = SHIFT;
            else if (sync[1]) state_d = IDLE;
         end
         SHIFT: begin
            if (timeout) begin
               ferr_d  = 1'b1;
               state_d = DRAIN;
            end else if (sclk_fall) begin
               sr_d  = {sr_q[WORD_WIDTH-2:0], sync[0]};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WORD_WIDTH - 1)) begin
                  done    = 1'b1;
                  state_d = DRAIN;
               end
            end else if (sync[1]) begin
               ferr_d  = 1'b1;
               state_d = IDLE;
            end
         end
         DRAIN: state_d = sync[1] ? IDLE : DRAIN;
         default: state_d = IDLE;
      endcase
      // a completing word always wins over the consumer's accept of the previous one
      if (done) begin
         par_d   = sr_d;
         valid_d = 1'b1;
         ovr_d   = valid_q && !bus.i_data_ready;
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         par_q   <= '0;
         wd_q    <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         par_q   <= par_d;
         wd_q    <= wd_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end
   assign bus.o_data_parallel = par_q;
   assign bus.o_data_valid    = valid_q;
   assign bus.o_overrun       = ovr_q;
   assign bus.o_frame_err     = ferr_q;
   assign bus.o_busy          = (state_q == ARMED) || (state_q == SHIFT);
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: scoreboard bench driving serializer-style traffic into deserializer.
module tb_deserializer;
   localparam int W = 12;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int pass_cnt = 0, total = 0, fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
   logic rnd_en = 1'b0, ready_val = 1'b1;
   logic [W-1:0] exp_q[$];

   deserializer_if #(.WORD_WIDTH(W)) bus();
   deserializer #(.WORD_WIDTH(W), .TIMEOUT_CYCLES(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [W-1:0] w, input int n, input int h);
      bus.i_data_sent = 1'b0;
      cyc(h);
      for (int i = 0; i < n; i++) begin
         bus.i_sclk = 1'b1;
         bus.i_data_serial = w[W-1-i];
         cyc(h);
         bus.i_sclk = 1'b0;
         cyc(h);
      end
   endtask

   task automatic finish_word(input int h);
      bus.i_sclk = 1'b1;
      bus.i_data_serial = 1'b0;
      cyc(h);
      bus.i_sclk = 1'b0;
      cyc(h);
      bus.i_data_sent = 1'b1;
      cyc(h + 4);
   endtask

   task automatic send_word(input logic [W-1:0] w);
      int h;
      h = $urandom_range(4, 8);
      send_bits(w, W, h);
      finish_word(h);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, bus.o_data_valid, 0);
      check({tag, "_word"}, bus.o_data_parallel, 0);
      check({tag, "_busy"}, bus.o_busy, 0);
      check({tag, "_overrun"}, bus.o_overrun, 0);
      check({tag, "_frame_err"}, bus.o_frame_err, 0);
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      bus.i_data_ready = rnd_en ? 1'($urandom_range(0, 1)) : ready_val;
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (bus.o_frame_err) fe_cnt++;
         if (bus.o_overrun) ov_cnt++;
         if (bus.o_data_valid && bus.i_data_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_word: got %0h expected none", bus.o_data_parallel);
            end else check("word", bus.o_data_parallel, exp_q.pop_front());
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      int n, h;
      logic [W-1:0] w;
      bus.i_sclk = 1'b0;
      bus.i_data_serial = 1'b0;
      bus.i_data_sent = 1'b1;
      bus.i_data_ready = 1'b1;
      cyc(3);
      check_reset_outputs("rst");
      rst = 1'b0;
      cyc(6);
      // basic word, including exact completion latency
      exp_q.push_back(12'hA5C);
      h = 6;
      send_bits(12'hA5C, W - 1, h);
      bus.i_sclk = 1'b1;
      bus.i_data_serial = 1'b0;
      cyc(h);
      bus.i_sclk = 1'b0;
      cyc(2);
      check("latency_pre", bus.o_data_valid, 0);
      cyc(1);
      check("latency_valid", bus.o_data_valid, 1);
      cyc(h - 3);
      finish_word(h);
      check("basic_drained", exp_q.size(), 0);
      // back-to-back with consumer stalled: first word is overwritten
      ready_val = 1'b0;
      cyc(3);
      send_word(12'hFFF);
      check("hold_valid", bus.o_data_valid, 1);
      check("hold_word", bus.o_data_parallel, 12'hFFF);
      exp_q.push_back(12'h001);
      exp_ov++;
      send_word(12'h001);
      check("ovr_count", ov_cnt, exp_ov);
      check("ovr_valid", bus.o_data_valid, 1);
      check("ovr_word", bus.o_data_parallel, 12'h001);
      ready_val = 1'b1;
      cyc(4);
      check("ovr_drained", exp_q.size(), 0);
      // truncated word
      w = 12'($urandom);
      send_bits(w, 5, 6);
      bus.i_data_sent = 1'b1;
      cyc(10);
      exp_fe++;
      check("trunc_ferr", fe_cnt, exp_fe);
      check("trunc_valid", bus.o_data_valid, 0);
      exp_q.push_back(12'h3C3);
      send_word(12'h3C3);
      check("trunc_next_drained", exp_q.size(), 0);
      // reset in the middle of a word
      send_bits(12'h800, 7, 5);
      rst = 1'b1;
      bus.i_data_sent = 1'b1;
      cyc(1);
      check_reset_outputs("rst_mid");
      cyc(2);
      rst = 1'b0;
      cyc(6);
      check("rst_mid_no_ferr", fe_cnt, exp_fe);
      exp_q.push_back(12'h123);
      send_word(12'h123);
      check("rst_next_drained", exp_q.size(), 0);
      // SCLK frozen after 4 bits
      w = 12'h9A7;
      h = 5;
      send_bits(w, 3, h);
      bus.i_sclk = 1'b1;
      bus.i_data_serial = w[W-4];
      cyc(h);
      bus.i_sclk = 1'b0;
`ifdef DESERIALIZER_TIMEOUT_EN
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (!bus.o_frame_err && n < 100);
      exp_fe++;
      check("wd_pulse", bus.o_frame_err, 1);
      check("wd_delay_in_window", int'(n >= 34 && n <= 37), 1);
      check("wd_busy", bus.o_busy, 0);
      check("wd_valid", bus.o_data_valid, 0);
      cyc(3);
      bus.i_data_sent = 1'b1;
      cyc(8);
      check("wd_ferr_count", fe_cnt, exp_fe);
`else
      cyc(100);
      check("stall_busy", bus.o_busy, 1);
      check("stall_no_ferr", fe_cnt, exp_fe);
      check("stall_valid", bus.o_data_valid, 0);
      rst = 1'b1;
      bus.i_data_sent = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(6);
`endif
      // zero-length transfer
      bus.i_data_sent = 1'b0;
      cyc(4);
      check("zl_busy", bus.o_busy, 1);
      bus.i_data_sent = 1'b1;
      cyc(8);
      check("zl_idle", bus.o_busy, 0);
      check("zl_no_ferr", fe_cnt, exp_fe);
      check("zl_valid", bus.o_data_valid, 0);
      // randomized words with a randomly stalling consumer
      rnd_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         w = 12'($urandom);
         exp_q.push_back(w);
         send_word(w);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         cyc(1);
         n++;
      end
      rnd_en = 1'b0;
      cyc(3);
      check("rand_drained", exp_q.size(), 0);
      check("final_ferr", fe_cnt, exp_fe);
      check("final_ovr", ov_cnt, exp_ov);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
